// File: rtl/matmul_ctrl.sv
// matmul_ctrl: command sequencer that checks dims, drives the engine through load/run and reports done, error and run length
module matmul_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_n_dim_i,
  input  logic [1:0]           cmd_k_dim_i,
  input  logic [1:0]           cmd_m_dim_i,
  input  logic                 cmd_mode_i,
  output logic [1:0]           n_dim_o,
  output logic [1:0]           k_dim_o,
  output logic [1:0]           m_dim_o,
  output logic                 mode_o,
  output logic                 start_o,
  input  logic                 finish_mul_i,
  input  logic [BUS_WIDTH-1:0] flags_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [BUS_WIDTH-1:0] status_flags_o,
  output logic [15:0]          cycle_count_o
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int LOAD_CYCLES = MAX_DIM * MAX_DIM;
  localparam int PW = $clog2(TIMEOUT_CYCLES > LOAD_CYCLES ? TIMEOUT_CYCLES : LOAD_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] ph_cnt;
  logic [15:0] cnt, cnt_inc;
  logic accept, legal, load_end, run_end;
  assign cmd_ready_o = (state == IDLE || state == ERR) && !rst_i;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign legal = int'(cmd_n_dim_i) < MAX_DIM && int'(cmd_k_dim_i) < MAX_DIM && int'(cmd_m_dim_i) < MAX_DIM;
  assign load_end = ph_cnt == PW'(LOAD_CYCLES - 1);
  assign run_end = ph_cnt == PW'(TIMEOUT_CYCLES - 1);
  assign cnt_inc = &cnt ? cnt : cnt + 16'd1;
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR: state_nxt = accept ? (legal ? LOAD : ERR) : state;
      LOAD:      state_nxt = load_end ? RUN : LOAD;
      RUN:       state_nxt = finish_mul_i ? DONE : run_end ? ERR : RUN;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    start_o = state == RUN;
    busy_o  = state == LOAD || state == RUN;
    done_o  = state == DONE;
    error_o = state == ERR;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_dim_o        <= '0;
      k_dim_o        <= '0;
      m_dim_o        <= '0;
      mode_o         <= 1'b0;
      status_flags_o <= '0;
      cycle_count_o  <= '0;
      cnt            <= '0;
      ph_cnt         <= '0;
    end else begin
      if (accept) begin
        n_dim_o <= cmd_n_dim_i;
        k_dim_o <= cmd_k_dim_i;
        m_dim_o <= cmd_m_dim_i;
        mode_o  <= cmd_mode_i;
        cnt     <= '0;
        ph_cnt  <= '0;
      end else if (busy_o) begin
        cnt    <= cnt_inc;
        ph_cnt <= (state == LOAD && load_end) ? PW'(0) : ph_cnt + PW'(1);
      end
      if (state == RUN && (finish_mul_i || run_end)) cycle_count_o <= cnt_inc;
      if (state == RUN && finish_mul_i) status_flags_o <= flags_i;
    end
  end
endmodule
